// File: rtl/mem_cmd_frontend_if.sv
// Client-side command/response handshake bundle for mem_cmd_frontend.
// The master modport is the requesting client; the slave modport is the frontend.
interface mem_cmd_frontend_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_cmd_frontend.sv
// Command FIFO + in-order issue + response FIFO in front of the 256x32 memory controller.
// Optional MEM_FE_STATS_EN adds saturating issued-write/read counters with a clear input.
module mem_cmd_frontend #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  mem_cmd_frontend_if.slave            client,
  output logic [ADDR_W-1:0]            mem_write_address,
  output logic [ADDR_W-1:0]            mem_read_address,
  output logic [DATA_W-1:0]            mem_data_in,
  output logic                         mem_write_enable,
  output logic                         mem_read_enable,
  input  logic [DATA_W-1:0]            mem_data_out,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count
`ifdef MEM_FE_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [15:0]                  stat_wr_cnt,
  output logic [15:0]                  stat_rd_cnt
`endif
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [RAW+1:0] RSP_LIM = RSP_DEPTH[RAW+1:0];

  logic              cmd_write_q [CMD_DEPTH];
  logic [ADDR_W-1:0] cmd_addr_q  [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_data_q  [CMD_DEPTH];
  logic [DATA_W-1:0] rsp_data_q  [RSP_DEPTH];

  logic [CAW:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [RAW:0] rsp_wr_ptr, rsp_rd_ptr, rsp_count;
  logic [1:0]   rd_inflight;
  logic         rd_vld_p1;
  logic         cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic         rsp_push, rsp_pop, rsp_empty, rsp_room;
  logic         issue_wr, issue_rd;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
  assign cmd_full  = (cmd_wr_ptr[CAW] != cmd_rd_ptr[CAW]) &&
                     (cmd_wr_ptr[CAW-1:0] == cmd_rd_ptr[CAW-1:0]);
  assign client.req_ready = !cmd_full;
  assign cmd_push  = client.req_valid && !cmd_full;

  assign head_write = cmd_write_q[cmd_rd_ptr[CAW-1:0]];
  assign head_addr  = cmd_addr_q[cmd_rd_ptr[CAW-1:0]];
  assign head_data  = cmd_data_q[cmd_rd_ptr[CAW-1:0]];

  // A read may only leave the FIFO if its response slot is already guaranteed.
  assign rsp_room = ({1'b0, rsp_count} + {{RAW{1'b0}}, rd_inflight}) < RSP_LIM;
  assign issue_wr = !cmd_empty && head_write;
  assign issue_rd = !cmd_empty && !head_write && rsp_room;
  assign cmd_pop  = issue_wr || issue_rd;

  assign rsp_empty        = (rsp_wr_ptr == rsp_rd_ptr);
  assign client.rsp_valid = !rsp_empty;
  assign client.rsp_rdata = rsp_data_q[rsp_rd_ptr[RAW-1:0]];
  assign rsp_pop          = !rsp_empty && client.rsp_ready;
  assign rsp_push         = rd_vld_p1;

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_write_q[cmd_wr_ptr[CAW-1:0]] <= client.req_write;
      cmd_addr_q[cmd_wr_ptr[CAW-1:0]]  <= client.req_addr;
      cmd_data_q[cmd_wr_ptr[CAW-1:0]]  <= client.req_wdata;
    end
    if (rsp_push) rsp_data_q[rsp_wr_ptr[RAW-1:0]] <= mem_data_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + {{CAW{1'b0}}, 1'b1};
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + {{CAW{1'b0}}, 1'b1};
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + {{CAW{1'b0}}, 1'b1};
        2'b01:   cmd_count <= cmd_count - {{CAW{1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end

  // Issue stage: registered controller port, one command per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write_enable  <= 1'b0;
      mem_read_enable   <= 1'b0;
      mem_write_address <= '0;
      mem_read_address  <= '0;
      mem_data_in       <= '0;
    end else begin
      mem_write_enable <= issue_wr;
      mem_read_enable  <= issue_rd;
      if (issue_wr) begin
        mem_write_address <= head_addr;
        mem_data_in       <= head_data;
      end
      if (issue_rd) mem_read_address <= head_addr;
    end
  end

  // Return stage: controller data_out is valid the cycle after read_enable was sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p1   <= 1'b0;
      rd_inflight <= '0;
      rsp_wr_ptr  <= '0;
      rsp_rd_ptr  <= '0;
      rsp_count   <= '0;
    end else begin
      rd_vld_p1 <= mem_read_enable;
      case ({issue_rd, rsp_push})
        2'b10:   rd_inflight <= rd_inflight + 2'd1;
        2'b01:   rd_inflight <= rd_inflight - 2'd1;
        default: ;
      endcase
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + {{RAW{1'b0}}, 1'b1};
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + {{RAW{1'b0}}, 1'b1};
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + {{RAW{1'b0}}, 1'b1};
        2'b01:   rsp_count <= rsp_count - {{RAW{1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end

`ifdef MEM_FE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else if (stat_clr) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      if (issue_wr) stat_wr_cnt <= sat_inc(stat_wr_cnt);
      if (issue_rd) stat_rd_cnt <= sat_inc(stat_rd_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_mem_cmd_frontend.sv
// Bench for mem_cmd_frontend: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against an in-order memory/scoreboard model.
module tb_mem_cmd_frontend;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_cmd_frontend_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cif ();
  logic [ADDR_W-1:0]          mem_write_address, mem_read_address;
  logic [DATA_W-1:0]          mem_data_in, mem_data_out;
  logic                       mem_write_enable, mem_read_enable;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
`ifdef MEM_FE_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

  mem_cmd_frontend #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH),
                     .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .client(cif),
    .mem_write_address(mem_write_address), .mem_read_address(mem_read_address),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_data_out(mem_data_out),
    .cmd_count(cmd_count)
`ifdef MEM_FE_STATS_EN
    , .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
  );

  // Behavioural 256x32 controller: registered read, cleared by reset.
  logic [DATA_W-1:0] ctl_mem [256];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ctl_mem[i] <= '0;
      mem_data_out <= '0;
    end else begin
      if (mem_write_enable) ctl_mem[mem_write_address] <= mem_data_in;
      if (mem_read_enable)  mem_data_out <= ctl_mem[mem_read_address];
    end
  end

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } vec_t;

  // Reference model: commands leave in acceptance order, reads see every earlier write.
  cmd_t              iss_q [$];
  logic [DATA_W-1:0] rsp_q [$];
  logic [DATA_W-1:0] ref_mem [256];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, we_cnt = 0, re_cnt = 0, rsp_seen = 0, max_cmd = 0;
  int last_we_cyc = 0, last_re_cyc = 0;
  bit rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d;
    iss_q.push_back(c);
    if (wr) ref_mem[a] = d;
    else    rsp_q.push_back(ref_mem[a]);
  endtask

  task automatic model_clear();
    iss_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  always @(negedge clk) begin : mon
    cmd_t e;
    if (!reset) begin
      if (int'(cmd_count) > max_cmd) max_cmd = int'(cmd_count);
      if (mem_write_enable || mem_read_enable) begin
        if (mem_write_enable) begin we_cnt++; last_we_cyc = cyc; end
        if (mem_read_enable)  begin re_cnt++; last_re_cyc = cyc; end
        chk("issue_single", {mem_write_enable, mem_read_enable}, mem_write_enable ? 2'b10 : 2'b01);
        if (iss_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL issue_unexpected: got issue at addr %0h expected none", 
                   mem_write_enable ? mem_write_address : mem_read_address);
        end else begin
          e = iss_q.pop_front();
          chk("issue_kind", mem_write_enable, e.wr);
          chk("issue_addr", mem_write_enable ? mem_write_address : mem_read_address, e.addr);
          if (e.wr) chk("issue_data", mem_data_in, e.data);
        end
      end
      if (cif.rsp_valid && cif.rsp_ready) begin
        rsp_seen++;
        if (rsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp_unexpected: got %0h expected none", cif.rsp_rdata);
        end else chk("rsp_data", cif.rsp_rdata, rsp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      output int waits);
    cif.req_valid = 1'b1; cif.req_write = wr; cif.req_addr = a; cif.req_wdata = d;
    waits = 0;
    while (!cif.req_ready && waits < 200) begin tick(); waits++; end
    if (!cif.req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got req_ready 0 expected 1 (addr %0h)", a);
    end else begin
      @(posedge clk);
      model_accept(wr, a, d);
      #1;
    end
    cif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!cif.rsp_valid && n < 50) begin tick(); n++; end
    if (!cif.rsp_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got rsp_valid 0 expected 1", name);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && n < 600) begin tick(); n++; end
    tick(); tick();
    chk({name, "_drained"}, iss_q.size() + rsp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cif.req_valid = 1'b0; cif.rsp_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin : wdog
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base_re, base_rsp;
    logic [DATA_W-1:0] bp_data [8];
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 8'h20, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 8'h21, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 8'h21, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b0, 8'h20, 32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 8'h33, 32'h0,        32'h0};
    vecs[7] = '{1'b1, 8'h10, 32'h0BADC0DE, 32'h0};
    vecs[8] = '{1'b0, 8'h10, 32'h0,        32'h0BADC0DE};

    cif.req_write = 1'b0; cif.req_addr = '0; cif.req_wdata = '0;
`ifdef MEM_FE_STATS_EN
    stat_clr = 1'b0;
`endif
    do_reset();
    chk("rst_req_ready", cif.req_ready, 1);
    chk("rst_rsp_valid", cif.rsp_valid, 0);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_re", mem_read_enable, 0);
    chk("rst_waddr", mem_write_address, 0);
    chk("rst_raddr", mem_read_address, 0);
    chk("rst_din", mem_data_in, 0);

    // Latency: accept at edge N, response visible after N+3.
    send(1'b0, 8'h05, '0, w);
    chk("lat_n0", cif.rsp_valid, 0);
    tick(); chk("lat_n1", cif.rsp_valid, 0);
    tick(); chk("lat_n2", cif.rsp_valid, 0);
    tick(); chk("lat_n3", cif.rsp_valid, 1);
    chk("lat_rdata", cif.rsp_rdata, 0);
    cif.rsp_ready = 1'b1;
    drain("lat");

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].data, w);
      if (!vecs[i].wr) begin
        wait_rsp("vec");
        chk($sformatf("vec%0d_rdata", i), cif.rsp_rdata, vecs[i].exp);
        tick();
      end
    end
    drain("vec");

    // Back-to-back write then read of the same address.
    base_rsp = rsp_seen;
    send(1'b1, 8'h40, 32'hA5A55A5A, w);
    send(1'b0, 8'h40, '0, w);
    drain("raw");
    chk("raw_re_after_we", last_re_cyc - last_we_cyc, 1);
    chk("raw_rsp_count", rsp_seen - base_rsp, 1);

    // Backpressure: 8 reads with the response side blocked.
    for (int i = 0; i < 8; i++) begin
      bp_data[i] = $urandom;
      send(1'b1, 8'h80 + 8'(i), bp_data[i], w);
    end
    drain("bp_fill");
    cif.rsp_ready = 1'b0;
    base_re = re_cnt; base_rsp = rsp_seen;
    for (int i = 0; i < 8; i++) send(1'b0, 8'h80 + 8'(i), '0, w);
    repeat (6) tick();
    chk("bp_re_pulses", re_cnt - base_re, RSP_DEPTH);
    chk("bp_req_ready", cif.req_ready, 0);
    chk("bp_cmd_count", cmd_count, CMD_DEPTH);
    chk("bp_rsp_valid", cif.rsp_valid, 1);
    chk("bp_head_data", cif.rsp_rdata, bp_data[0]);
    cif.rsp_ready = 1'b1;
    drain("bp");
    chk("bp_rsp_total", rsp_seen - base_rsp, 8);
    chk("bp_re_total", re_cnt - base_re, 8);

    // Full/wrap: 12 writes then 12 reads.
    base_rsp = rsp_seen; max_cmd = 0;
    for (int i = 0; i < 12; i++) send(1'b1, 8'(i), $urandom, w);
    for (int i = 0; i < 12; i++) send(1'b0, 8'(i), '0, w);
    drain("wrap");
    chk("wrap_rsp_total", rsp_seen - base_rsp, 12);
    chk("wrap_max_count_ok", max_cmd <= CMD_DEPTH, 1);

    // Steady accept/issue with the command FIFO near full.
    cif.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'(i), '0, w);
    repeat (6) tick();
    send(1'b0, 8'h04, '0, w);
    for (int i = 0; i < 3; i++) send(1'b1, 8'h90 + 8'(i), $urandom, w);
    chk("pp_full_count", cmd_count, CMD_DEPTH);
    chk("pp_full_ready", cif.req_ready, 0);
    cif.rsp_ready = 1'b1;
    send(1'b1, 8'h93, $urandom, w);
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 8'h94 + 8'(i), $urandom, w);
      chk($sformatf("pp%0d_waits", i), w, 0);
      chk($sformatf("pp%0d_count", i), cmd_count, CMD_DEPTH - 1);
    end
    drain("pp");

    // Randomized traffic with random response backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, w);
          repeat ($urandom_range(0, 2)) tick();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          cif.rsp_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    cif.rsp_ready = 1'b1;
    drain("rand");

    // Reset with two reads in flight and three commands queued.
    cif.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'h50 + 8'(i), '0, w);
    repeat (6) tick();
    for (int i = 0; i < 4; i++) send(1'b0, 8'h60 + 8'(i), '0, w);
    cif.rsp_ready = 1'b1;
    cif.req_valid = 1'b1; cif.req_write = 1'b0; cif.req_addr = 8'h70;
    tick(); tick();
    cif.rsp_ready = 1'b0;
    chk("rm_req_ready", cif.req_ready, 1);
    @(posedge clk);
    model_accept(1'b0, 8'h70, '0);
    #1 cif.req_valid = 1'b0;
    chk("rm_pre_count", cmd_count, 3);
    chk("rm_pre_re", mem_read_enable, 1);
    reset = 1'b1;
    model_clear();
    #1;
    chk("rm_rsp_valid", cif.rsp_valid, 0);
    chk("rm_cmd_count", cmd_count, 0);
    chk("rm_we", mem_write_enable, 0);
    chk("rm_re", mem_read_enable, 0);
    chk("rm_req_ready", cif.req_ready, 1);
`ifdef MEM_FE_STATS_EN
    chk("rm_stat_wr", stat_wr_cnt, 0);
    chk("rm_stat_rd", stat_rd_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cif.rsp_ready = 1'b1;
    send(1'b0, 8'hFF, '0, w);
    wait_rsp("post_rst");
    chk("post_rst_rdata", cif.rsp_rdata, 0);
    drain("post_rst");

`ifdef MEM_FE_STATS_EN
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    chk("stat_clr_wr", stat_wr_cnt, 0);
    for (int i = 0; i < 65540; i++) send(1'b1, 8'(i), 32'(i), w);
    drain("stat");
    chk("stat_sat_wr", stat_wr_cnt, 16'hFFFF);
    chk("stat_rd_zero", stat_rd_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
